// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Lets two requesters share one ALU_Control + ALU datapath. req0 (core
// execute stage) has fixed priority over req1 (secondary unit). A starvation
// counter forces req1 to win after STARVE_MAX consecutive cycles in which
// req0 took the slot while req1 was waiting. The winner's fields drive the
// shared ALU inputs combinationally. The ALU result is captured into a
// one-entry response buffer, so latency is one cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready_o depends combinationally on reqN_valid_i, so
// requesters must not gate valid on ready. resp_valid_o stays high and
// resp_* stay stable until the rising edge where resp_ready_i is high.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid_i/ready_o     request handshake, N = 0,1
//   reqN_a_i, reqN_b_i       operands
//   reqN_alu_co_i            ALU class: 00 ld/st, 01 branch, 10 ALU
//   reqN_func3_i/func7_i     instruction function fields
//   reqN_is_imm_i            immediate-form flag
//   alu_a_o .. is_imm_o      shared ALU / ALU_Control inputs
//   alu_result_i/zero_i      combinational ALU result and zero flag
//   resp_valid_o/ready_i     response handshake
//   resp_id_o                requester that owns the response
//   resp_result_o/zero_o     captured result and zero flag
//   dbg_state_o              FSM state (0 EMPTY, 1 FULL)
//   dbg_starve_cnt_o         starvation counter
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [XLEN-1:0]  req0_a_i,
  input  logic [XLEN-1:0]  req0_b_i,
  input  logic [1:0]       req0_alu_co_i,
  input  logic [2:0]       req0_func3_i,
  input  logic [6:0]       req0_func7_i,
  input  logic             req0_is_imm_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [XLEN-1:0]  req1_a_i,
  input  logic [XLEN-1:0]  req1_b_i,
  input  logic [1:0]       req1_alu_co_i,
  input  logic [2:0]       req1_func3_i,
  input  logic [6:0]       req1_func7_i,
  input  logic             req1_is_imm_i,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [1:0]       alu_co_o,
  output logic [2:0]       func3_o,
  output logic [6:0]       func7_o,
  output logic             is_imm_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic             alu_zero_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [XLEN-1:0]  resp_result_o,
  output logic             resp_zero_o,
  output logic             dbg_state_o,
  output logic [CNT_W-1:0] dbg_starve_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q;
  logic              resp_valid_q;
  logic              resp_id_q;
  logic [XLEN-1:0]   resp_result_q;
  logic              resp_zero_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;

  logic slot_free;
  logic win0;
  logic win1;
  logic accept;
  logic starved;

  always_comb begin
    starved = (starve_q == CNT_W'(STARVE_MAX));
    // Reset is async, so the slot is also closed while rst is held: nothing
    // may be accepted into a buffer that is being cleared.
    slot_free = !rst && ((state_q == EMPTY) || resp_ready_i);
    win1      = req1_valid_i && (!req0_valid_i || starved);
    win0      = req0_valid_i && !win1;
    accept    = (win0 || win1) && slot_free;
    req0_ready_o = slot_free && win0;
    req1_ready_o = slot_free && win1;
  end

  // Shared ALU inputs follow the winner even while the slot is blocked; with
  // no requester they are all zero (alu_co 00 selects SUM).
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_co_o = '0;
    func3_o  = '0;
    func7_o  = '0;
    is_imm_o = 1'b0;
    if (win1) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_co_o = req1_alu_co_i;
      func3_o  = req1_func3_i;
      func7_o  = req1_func7_i;
      is_imm_o = req1_is_imm_i;
    end else if (win0) begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_co_o = req0_alu_co_i;
      func3_o  = req0_func3_i;
      func7_o  = req0_func7_i;
      is_imm_o = req0_is_imm_i;
    end
  end

  // Starvation counter: counts req0 grants while req1 waits; it does not move
  // while the slot is blocked.
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid_i || (accept && win1)) begin
      starve_d = '0;
    end else if (accept && win0 && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Response buffer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q       <= FULL;
            resp_valid_q  <= 1'b1;
            resp_id_q     <= win1;
            resp_result_q <= alu_result_i;
            resp_zero_q   <= alu_zero_i;
          end
        end
        FULL: begin
          if (resp_ready_i) begin
            if (accept) begin
              // Back-to-back: the drained entry is replaced in the same edge.
              resp_id_q     <= win1;
              resp_result_q <= alu_result_i;
              resp_zero_q   <= alu_zero_i;
            end else begin
              state_q      <= EMPTY;
              resp_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= EMPTY;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_id_o        = resp_id_q;
  assign resp_result_o    = resp_result_q;
  assign resp_zero_o      = resp_zero_q;
  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(STARVE_MAX + 1);
  localparam int W          = XLEN + 2;  // {id, zero, result}

  logic             clk;
  logic             rst;
  logic             req0_valid_i, req1_valid_i;
  logic             req0_ready_o, req1_ready_o;
  logic [XLEN-1:0]  req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [1:0]       req0_alu_co_i, req1_alu_co_i;
  logic [2:0]       req0_func3_i, req1_func3_i;
  logic [6:0]       req0_func7_i, req1_func7_i;
  logic             req0_is_imm_i, req1_is_imm_i;
  logic [XLEN-1:0]  alu_a_o, alu_b_o;
  logic [1:0]       alu_co_o;
  logic [2:0]       func3_o;
  logic [6:0]       func7_o;
  logic             is_imm_o;
  logic [XLEN-1:0]  alu_result_i;
  logic             alu_zero_i;
  logic             resp_valid_o, resp_ready_i, resp_id_o, resp_zero_o;
  logic [XLEN-1:0]  resp_result_o;
  logic             dbg_state_o;
  logic [CNT_W-1:0] dbg_starve_cnt_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_alu_co_i(req0_alu_co_i),
    .req0_func3_i(req0_func3_i), .req0_func7_i(req0_func7_i), .req0_is_imm_i(req0_is_imm_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_alu_co_i(req1_alu_co_i),
    .req1_func3_i(req1_func3_i), .req1_func7_i(req1_func7_i), .req1_is_imm_i(req1_is_imm_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_co_o(alu_co_o),
    .func3_o(func3_o), .func7_o(func7_o), .is_imm_o(is_imm_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_result_o(resp_result_o), .resp_zero_o(resp_zero_o),
    .dbg_state_o(dbg_state_o), .dbg_starve_cnt_o(dbg_starve_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external ALU model ----------------
  function automatic logic [XLEN:0] alu_model(input logic [1:0] co, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic imm,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (co)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: begin
        case (f3)
          3'b000: r = (f7[5] && !imm) ? a - b : a + b;
          3'b001: r = a << b[4:0];
          3'b010: r = ($signed(a) < $signed(b)) ? 1 : 0;
          3'b011: r = (a < b) ? 1 : 0;
          3'b100: r = a ^ b;
          3'b101: r = f7[5] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'b110: r = a | b;
          default: r = a & b;
        endcase
      end
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {alu_zero_i, alu_result_i} = alu_model(alu_co_o, func3_o, func7_o, is_imm_o, alu_a_o, alu_b_o);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req0(input logic v, input logic [1:0] co, input logic [2:0] f3,
                          input logic [6:0] f7, input logic imm,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req0_valid_i = v; req0_alu_co_i = co; req0_func3_i = f3;
    req0_func7_i = f7; req0_is_imm_i = imm; req0_a_i = a; req0_b_i = b;
  endtask

  task automatic set_req1(input logic v, input logic [1:0] co, input logic [2:0] f3,
                          input logic [6:0] f7, input logic imm,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req1_valid_i = v; req1_alu_co_i = co; req1_func3_i = f3;
    req1_func7_i = f7; req1_is_imm_i = imm; req1_a_i = a; req1_b_i = b;
  endtask

  task automatic rand_req0(input logic v);
    set_req0(v, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom, ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom);
  endtask

  task automatic rand_req1(input logic v);
    set_req1(v, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 1'($urandom_range(0, 1)),
             $urandom, $urandom);
  endtask

  // One cycle: inputs are already set at a falling edge. Scoreboard pops a
  // response being consumed, pushes the expectation for any accepted request,
  // then waits for the next falling edge.
  task automatic tick();
    logic [W-1:0] e;
    #1;
    if (resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("resp", 64'({resp_id_o, resp_zero_o, resp_result_o}), 64'(e));
      end
    end
    check("ready_onehot", 64'(req0_ready_o & req1_ready_o), 64'(0));
    if (req0_ready_o)
      exp_q.push_back({1'b0, alu_model(req0_alu_co_i, req0_func3_i, req0_func7_i,
                                       req0_is_imm_i, req0_a_i, req0_b_i)});
    if (req1_ready_o)
      exp_q.push_back({1'b1, alu_model(req1_alu_co_i, req1_func3_i, req1_func7_i,
                                       req1_is_imm_i, req1_a_i, req1_b_i)});
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    rst = 1'b1;
    resp_ready_i = 1'b1;
    set_req0(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    set_req1(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(resp_valid_o), 64'(0));
    check("rst_resp", 64'({resp_id_o, resp_zero_o, resp_result_o}), 64'(0));
    check("rst_starve", 64'(dbg_starve_cnt_o), 64'(0));
    check("rst_state", 64'(dbg_state_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single req1 SUB 10-3.
    set_req1(1'b1, 2'b10, 3'b000, 7'h20, 1'b0, 32'd10, 32'd3);
    #1;
    check("r1_func7", 64'(func7_o), 64'(7'h20));
    check("r1_alu_a", 64'(alu_a_o), 64'(10));
    check("r1_ready", 64'({req0_ready_o, req1_ready_o}), 64'(2'b01));
    tick();
    set_req1(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    #1;
    check("r1_resp", 64'({resp_valid_o, resp_id_o, resp_result_o}), 64'({1'b1, 1'b1, 32'd7}));
    tick();

    // Branch pass-through with equal operands.
    set_req0(1'b1, 2'b01, 3'b000, 7'h00, 1'b0, 32'd9, 32'd9);
    tick();
    set_req0(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    #1;
    check("br_resp", 64'({resp_valid_o, resp_id_o, resp_zero_o}), 64'(3'b101));
    tick();

    // Contention: grants 0,0,0,0,1 repeating.
    for (int k = 0; k < 12; k++) begin
      rand_req0(1'b1);
      rand_req1(1'b1);
      #1;
      check("grant_r1", 64'(req1_ready_o), 64'((k % 5) == 4));
      tick();
    end
    check("starve_after_cont", 64'(dbg_starve_cnt_o), 64'(2));

    // Backpressure for 3 cycles while FULL.
    resp_ready_i = 1'b0;
    #1;
    held = {resp_id_o, resp_zero_o, resp_result_o};
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 64'({req0_ready_o, req1_ready_o}), 64'(0));
      check("bp_hold", 64'({resp_valid_o, resp_id_o, resp_zero_o, resp_result_o}), 64'({1'b1, held}));
      check("bp_starve", 64'(dbg_starve_cnt_o), 64'(2));
      tick();
      #1;
    end
    resp_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'({req0_ready_o, req1_ready_o}), 64'(2'b10));
    tick();
    check("bp_release_full", 64'(resp_valid_o), 64'(1));
    check("bp_release_starve", 64'(dbg_starve_cnt_o), 64'(3));

    // Reset while FULL.
    resp_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(resp_valid_o), 64'(0));
    check("mid_rst_ready", 64'({req0_ready_o, req1_ready_o}), 64'(0));
    check("mid_rst_starve", 64'(dbg_starve_cnt_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    resp_ready_i = 1'b1;
    set_req1(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    set_req0(1'b1, 2'b10, 3'b000, 7'h00, 1'b0, 32'd5, 32'd7);
    tick();

    // Idle: ALU inputs zero, response drains.
    set_req0(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    #1;
    check("add_resp", 64'({resp_valid_o, resp_id_o, resp_result_o}), 64'({1'b1, 1'b0, 32'd12}));
    check("idle_alu_ab", 64'(alu_a_o | alu_b_o), 64'(0));
    check("idle_alu_ctl", 64'({alu_co_o, func3_o, func7_o, is_imm_o}), 64'(0));
    tick();
    check("idle_drained", 64'(resp_valid_o), 64'(0));
    check("idle_starve", 64'(dbg_starve_cnt_o), 64'(0));

    // Random traffic through the scoreboard.
    for (int k = 0; k < 400; k++) begin
      rand_req0(1'($urandom_range(0, 1)));
      rand_req1(1'($urandom_range(0, 3) != 0));
      resp_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    set_req0(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    set_req1(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, '0, '0);
    resp_ready_i = 1'b1;
    tick();
    tick();
    check("final_empty", 64'(resp_valid_o), 64'(0));
    check("final_queue", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
